// File: rtl/sd_dma_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_dma_wb_arbiter_if
// One point-to-point Wishbone link. Data direction names are from the
// master's point of view: dout carries write data out of the master, din
// carries read data back into it.
//
// Signals:
//   addr[31:0]  address                (master -> slave)
//   dout[31:0]  write data             (master -> slave)
//   din[31:0]   read data              (slave  -> master)
//   dm[3:0]     byte enables           (master -> slave)
//   cyc/stb/we  bus cycle controls     (master -> slave)
//   ack         transfer acknowledge   (slave  -> master)
//
// Modports:
//   master : the side that starts cycles
//   slave  : the side that answers them
// ---------------------------------------------------------------------------
interface sd_dma_wb_arbiter_if;
  logic [31:0] addr;
  logic [31:0] dout;
  logic [31:0] din;
  logic [3:0]  dm;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output addr, dout, dm, cyc, stb, we, input din, ack);
  modport slave  (input addr, dout, dm, cyc, stb, we, output din, ack);
endinterface

// File: rtl/sd_dma_wb_arbiter.sv
// ---------------------------------------------------------------------------
// sd_dma_wb_arbiter
// Two-master / one-slave Wishbone arbiter placed between the CPU data master
// (m0), the SD controller DMA master (m1) and system memory (s). Round-robin
// with a held grant: once a master owns the bus it keeps it until its cyc
// drops, so DMA block bursts are never split. One idle cycle always
// separates two owners.
//
// Ports:
//   wb_clk       bus clock, rising edge
//   wb_rst       asynchronous active-high reset
//   m0           CPU master link        (slave modport)
//   m1           SD DMA master link     (slave modport)
//   s            memory slave link      (master modport)
//   grant[1:0]   one-hot owner, bit0=m0, bit1=m1, 00 when idle
//   timeout_evt  one-cycle pulse when a stalled access is aborted
//
// Parameters:
//   TIMEOUT_W    stall counter width; abort after 2^TIMEOUT_W-1 stalled cycles
//   RESET_LAST   last-served master after reset (1 -> m0 wins first contention)
//
// Optional build macro SD_DMA_WB_ARBITER_TIMEOUT_EN adds the stall timeout.
// Without it, timeout_evt is constant 0 and a silent slave hangs the bus.
// ---------------------------------------------------------------------------
module sd_dma_wb_arbiter #(
  parameter int TIMEOUT_W  = 10,
  parameter bit RESET_LAST = 1'b1
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  sd_dma_wb_arbiter_if.slave   m0,
  sd_dma_wb_arbiter_if.slave   m1,
  sd_dma_wb_arbiter_if.master  s,
  output logic [1:0]           grant,
  output logic                 timeout_evt
);

  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;   // 0: m0 served last, 1: m1 served last
  logic   tmo_hit;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      last  <= RESET_LAST;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Ownership only changes through IDLE, which enforces the bus-idle gap.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          if (last) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
          end
        end else if (m0.cyc) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
        end else if (m1.cyc) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
        end
      end
      OWN0:    if (!m0.cyc) state_nxt = IDLE;
      OWN1:    if (!m1.cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant       = {state == OWN1, state == OWN0};
  assign timeout_evt = tmo_hit;

  // Bus routing follows the registered owner only; nothing reaches the
  // slave in IDLE. A timeout replaces the slave's answer with a synthetic
  // ack carrying TMO_DATA and withdraws stb for that cycle.
  always_comb begin
    s.addr = '0;
    s.dout = '0;
    s.dm   = '0;
    s.cyc  = 1'b0;
    s.stb  = 1'b0;
    s.we   = 1'b0;
    m0.ack = 1'b0;
    m0.din = '0;
    m1.ack = 1'b0;
    m1.din = '0;
    case (state)
      OWN0: begin
        s.addr = m0.addr;
        s.dout = m0.dout;
        s.dm   = m0.dm;
        s.cyc  = m0.cyc;
        s.stb  = m0.stb & ~tmo_hit;
        s.we   = m0.we;
        m0.ack = s.ack | tmo_hit;
        m0.din = tmo_hit ? TMO_DATA : s.din;
      end
      OWN1: begin
        s.addr = m1.addr;
        s.dout = m1.dout;
        s.dm   = m1.dm;
        s.cyc  = m1.cyc;
        s.stb  = m1.stb & ~tmo_hit;
        s.we   = m1.we;
        m1.ack = s.ack | tmo_hit;
        m1.din = tmo_hit ? TMO_DATA : s.din;
      end
      default: ;
    endcase
  end

`ifdef SD_DMA_WB_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == '1);

  // Counts cycles with stb presented and no ack. Restarts on any ack, on
  // the abort itself and whenever the owner releases the bus.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)
      tmo_cnt <= '0;
    else if (state_nxt == IDLE || s.ack || tmo_hit)
      tmo_cnt <= '0;
    else if (s.stb)
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
  end
`else
  // No stall counter; the abort path stays constant 0.
  assign tmo_hit = (TIMEOUT_W < 0);
`endif

endmodule

// File: tb/tb_sd_dma_wb_arbiter.sv
module tb_sd_dma_wb_arbiter;
  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [1:0] grant;
  logic       timeout_evt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sd_dma_wb_arbiter_if m0_if ();
  sd_dma_wb_arbiter_if m1_if ();
  sd_dma_wb_arbiter_if s_if ();

  sd_dma_wb_arbiter #(.TIMEOUT_W(4), .RESET_LAST(1'b1)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m0_if.addr = '0; m0_if.dout = '0; m0_if.dm = '0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
    m1_if.addr = '0; m1_if.dout = '0; m1_if.dm = '0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    s_if.din = '0; s_if.ack = 1'b0;
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge wb_clk); wb_rst = 1'b1;
    @(negedge wb_clk); wb_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    wb_rst = 1'b1;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.addr = 32'h1234;
    s_if.ack = 1'b1; s_if.din = 32'h55;
    #12;
    total_cnt++;
    if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
    else pass_cnt++;
    total_cnt++;
    if ({s_if.cyc, s_if.stb, s_if.we, s_if.dm, s_if.addr, s_if.dout} !== 71'd0)
      $display("FAIL reset_slave_outs: got %h want 0",
               {s_if.cyc, s_if.stb, s_if.we, s_if.dm, s_if.addr, s_if.dout});
    else pass_cnt++;
    total_cnt++;
    if ({m0_if.ack, m1_if.ack, m0_if.din, m1_if.din} !== 66'd0)
      $display("FAIL reset_master_outs: got %h want 0",
               {m0_if.ack, m1_if.ack, m0_if.din, m1_if.din});
    else pass_cnt++;
    total_cnt++;
    if (timeout_evt !== 1'b0) $display("FAIL reset_timeout_evt: got %b want 0", timeout_evt);
    else pass_cnt++;
    clear_inputs();
    @(negedge wb_clk); wb_rst = 1'b0;
  endtask

  task automatic test_m1_alone();
    step();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1;
    m1_if.addr = 32'h0010_0000; m1_if.dout = 32'h1234_5678; m1_if.dm = 4'hF;
    @(negedge wb_clk);
    total_cnt++;
    if ({s_if.cyc, s_if.stb, grant} !== 4'b0000)
      $display("FAIL idle_no_drive: got cyc/stb/grant %b want 0000", {s_if.cyc, s_if.stb, grant});
    else pass_cnt++;
    @(negedge wb_clk);
    total_cnt++;
    if ({s_if.cyc, s_if.stb, s_if.we, s_if.dm} !== 7'b111_1111)
      $display("FAIL m1_ctrl: got %b want 1111111", {s_if.cyc, s_if.stb, s_if.we, s_if.dm});
    else pass_cnt++;
    total_cnt++;
    if ({s_if.addr, s_if.dout} !== {32'h0010_0000, 32'h1234_5678})
      $display("FAIL m1_addr_data: got %h want 0010000012345678", {s_if.addr, s_if.dout});
    else pass_cnt++;
    total_cnt++;
    if (grant !== 2'b10) $display("FAIL m1_grant: got %b want 10", grant);
    else pass_cnt++;
    step();
    s_if.ack = 1'b1;
    @(negedge wb_clk);
    total_cnt++;
    if ({m1_if.ack, m0_if.ack} !== 2'b10)
      $display("FAIL m1_ack_route: got m1/m0 ack %b want 10", {m1_if.ack, m0_if.ack});
    else pass_cnt++;
    step();
    clear_inputs();
    step(); step();
  endtask

  task automatic test_alternation();
    pulse_reset();
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.addr = 32'hA000_0000;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.addr = 32'hB000_0000;
    @(negedge wb_clk);
    total_cnt++;
    if (grant !== 2'b00) $display("FAIL alt_latency: got %b want 00", grant);
    else pass_cnt++;
    @(negedge wb_clk);
    total_cnt++;
    if ({grant, s_if.addr} !== {2'b01, 32'hA000_0000})
      $display("FAIL alt_first_m0: got %b/%h want 01/a0000000", grant, s_if.addr);
    else pass_cnt++;
    step();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    @(negedge wb_clk);
    @(negedge wb_clk);
    total_cnt++;
    if ({grant, s_if.cyc} !== 3'b000)
      $display("FAIL alt_idle_gap: got grant/cyc %b want 000", {grant, s_if.cyc});
    else pass_cnt++;
    @(negedge wb_clk);
    total_cnt++;
    if ({grant, s_if.addr} !== {2'b10, 32'hB000_0000})
      $display("FAIL alt_then_m1: got %b/%h want 10/b0000000", grant, s_if.addr);
    else pass_cnt++;
    step();
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    total_cnt++;
    if (grant !== 2'b01) $display("FAIL alt_second_m0: got %b want 01", grant);
    else pass_cnt++;
    step();
    clear_inputs();
    step(); step();
  endtask

  task automatic test_burst();
    int acked = 0;
    int bad = 0;
    int cyc_n = 0;
    int n = 0;
    step();
    m1_if.cyc = 1'b1; m1_if.we = 1'b1;
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    while (acked < 128 && cyc_n < 2000) begin
      m1_if.stb = ($urandom_range(3) != 0);
      m1_if.dout = $urandom;
      s_if.ack = m1_if.stb;
      @(negedge wb_clk);
      if (grant !== 2'b10 || m0_if.ack !== 1'b0 || s_if.cyc !== 1'b1) bad++;
      if (m1_if.stb && s_if.dout !== m1_if.dout) bad++;
      if (m1_if.ack === 1'b1) acked++;
      step();
      cyc_n++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL burst_hold: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (acked != 128) $display("FAIL burst_words: got %0d want 128", acked);
    else pass_cnt++;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; s_if.ack = 1'b0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (grant !== 2'b01 && n < 10);
    total_cnt++;
    if (n - 1 != 2) $display("FAIL burst_handover: got %0d edges want 2", n - 1);
    else pass_cnt++;
    step();
    clear_inputs();
    step(); step();
  endtask

  task automatic test_read();
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0;
    step();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    s_if.din = 32'hCAFE_F00D; s_if.ack = 1'b1;
    @(negedge wb_clk);
    total_cnt++;
    if (m0_if.din !== 32'hCAFE_F00D) $display("FAIL read_owner_din: got %h want cafef00d", m0_if.din);
    else pass_cnt++;
    total_cnt++;
    if ({m1_if.din, m1_if.ack, m0_if.ack} !== {32'h0, 1'b0, 1'b1})
      $display("FAIL read_nonowner: got din %h ack %b/%b want 0 0/1", m1_if.din, m1_if.ack, m0_if.ack);
    else pass_cnt++;
    step();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    @(negedge wb_clk);
    total_cnt++;
    if ({m0_if.ack, s_if.cyc} !== 2'b10)
      $display("FAIL ack_with_drop: got ack/cyc %b want 10", {m0_if.ack, s_if.cyc});
    else pass_cnt++;
    @(negedge wb_clk);
    total_cnt++;
    if ({grant, m1_if.ack} !== 3'b000)
      $display("FAIL drop_to_idle: got grant/m1ack %b want 000", {grant, m1_if.ack});
    else pass_cnt++;
    @(negedge wb_clk);
    total_cnt++;
    if (grant !== 2'b10) $display("FAIL read_next_owner: got %b want 10", grant);
    else pass_cnt++;
    step();
    clear_inputs();
    step(); step();
  endtask

  task automatic test_reset_mid();
    step();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    @(negedge wb_clk);
    total_cnt++;
    if ({s_if.cyc, grant} !== 3'b110)
      $display("FAIL rstmid_pre: got cyc/grant %b want 110", {s_if.cyc, grant});
    else pass_cnt++;
    #2 wb_rst = 1'b1;
    #1;
    total_cnt++;
    if ({s_if.cyc, grant} !== 3'b000)
      $display("FAIL rstmid_async: got cyc/grant %b want 000", {s_if.cyc, grant});
    else pass_cnt++;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    @(negedge wb_clk); wb_rst = 1'b0;
    @(negedge wb_clk);
    total_cnt++;
    if (grant !== 2'b01) $display("FAIL rstmid_after: got %b want 01", grant);
    else pass_cnt++;
    step();
    clear_inputs();
    step(); step();
  endtask

  task automatic test_timeout();
    int n = 0;
    int k = 0;
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; s_if.ack = 1'b0; s_if.din = 32'h1111_2222;
    @(negedge wb_clk);
`ifdef SD_DMA_WB_ARBITER_TIMEOUT_EN
    while (k < 40) begin
      @(negedge wb_clk);
      k++;
      if (m0_if.ack === 1'b1) break;
      if (s_if.stb === 1'b1) n++;
    end
    total_cnt++;
    if (n != 15) $display("FAIL tmo_stall_len: got %0d want 15", n);
    else pass_cnt++;
    total_cnt++;
    if ({m0_if.ack, m0_if.din, timeout_evt, s_if.stb} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0})
      $display("FAIL tmo_abort: got ack %b din %h evt %b stb %b want 1 deadbeef 1 0",
               m0_if.ack, m0_if.din, timeout_evt, s_if.stb);
    else pass_cnt++;
    @(negedge wb_clk);
    total_cnt++;
    if ({timeout_evt, m0_if.ack, s_if.stb, grant} !== 5'b00101)
      $display("FAIL tmo_after: got evt/ack/stb/grant %b want 00101",
               {timeout_evt, m0_if.ack, s_if.stb, grant});
    else pass_cnt++;
`else
    while (k < 40) begin
      @(negedge wb_clk);
      k++;
      if (m0_if.ack === 1'b1 || timeout_evt !== 1'b0) n++;
    end
    total_cnt++;
    if (n != 0) $display("FAIL stall_hang: got %0d ack/evt cycles want 0", n);
    else pass_cnt++;
    total_cnt++;
    if ({s_if.stb, grant} !== 3'b101)
      $display("FAIL stall_owner: got stb/grant %b want 101", {s_if.stb, grant});
    else pass_cnt++;
`endif
    step();
    clear_inputs();
    step(); step();
  endtask

  // Reference model: who owns the bus, and who was served last.
  task automatic test_random();
    int owner = 0;       // 0 none, 1 m0, 2 m1
    int last_srv = 1;    // 0 m0, 1 m1
    int len0 = 0;
    int len1 = 0;
    int since_ack = 0;
    logic [1:0]  exp_grant;
    logic [70:0] exp_s;
    logic [32:0] exp_m0, exp_m1;
    clear_inputs();
    pulse_reset();
    for (int i = 0; i < 500; i++) begin
      @(posedge wb_clk);
      if (owner == 0) begin
        if (m0_if.cyc && m1_if.cyc) owner = (last_srv == 1) ? 1 : 2;
        else if (m0_if.cyc) owner = 1;
        else if (m1_if.cyc) owner = 2;
        if (owner != 0) last_srv = owner - 1;
      end else if ((owner == 1 && !m0_if.cyc) || (owner == 2 && !m1_if.cyc)) begin
        owner = 0;
      end
      #1;
      if (!m0_if.cyc) begin
        if ($urandom_range(3) == 0) begin m0_if.cyc = 1'b1; len0 = $urandom_range(12, 1); end
      end else if (len0 == 0) m0_if.cyc = 1'b0;
      else len0--;
      if (!m1_if.cyc) begin
        if ($urandom_range(3) == 0) begin m1_if.cyc = 1'b1; len1 = $urandom_range(12, 1); end
      end else if (len1 == 0) m1_if.cyc = 1'b0;
      else len1--;
      m0_if.stb = 1'($urandom_range(1)); m0_if.we = 1'($urandom_range(1));
      m0_if.addr = $urandom; m0_if.dout = $urandom; m0_if.dm = 4'($urandom_range(15));
      m1_if.stb = 1'($urandom_range(1)); m1_if.we = 1'($urandom_range(1));
      m1_if.addr = $urandom; m1_if.dout = $urandom; m1_if.dm = 4'($urandom_range(15));
      s_if.din = $urandom;
      s_if.ack = (since_ack >= 6) ? 1'b1 : 1'($urandom_range(1));
      since_ack = s_if.ack ? 0 : since_ack + 1;
      @(negedge wb_clk);
      exp_grant = 2'b00; exp_s = '0; exp_m0 = '0; exp_m1 = '0;
      if (owner == 1) begin
        exp_grant = 2'b01;
        exp_s = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.dm, m0_if.addr, m0_if.dout};
        exp_m0 = {s_if.ack, s_if.din};
      end else if (owner == 2) begin
        exp_grant = 2'b10;
        exp_s = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.dm, m1_if.addr, m1_if.dout};
        exp_m1 = {s_if.ack, s_if.din};
      end
      total_cnt++;
      if (grant !== exp_grant) $display("FAIL rnd_grant[%0d]: got %b want %b", i, grant, exp_grant);
      else pass_cnt++;
      total_cnt++;
      if ({s_if.cyc, s_if.stb, s_if.we, s_if.dm, s_if.addr, s_if.dout} !== exp_s)
        $display("FAIL rnd_slave[%0d]: got %h want %h", i,
                 {s_if.cyc, s_if.stb, s_if.we, s_if.dm, s_if.addr, s_if.dout}, exp_s);
      else pass_cnt++;
      total_cnt++;
      if ({m0_if.ack, m0_if.din} !== exp_m0)
        $display("FAIL rnd_m0[%0d]: got %h want %h", i, {m0_if.ack, m0_if.din}, exp_m0);
      else pass_cnt++;
      total_cnt++;
      if ({m1_if.ack, m1_if.din} !== exp_m1)
        $display("FAIL rnd_m1[%0d]: got %h want %h", i, {m1_if.ack, m1_if.din}, exp_m1);
      else pass_cnt++;
    end
    step();
    clear_inputs();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_m1_alone();
    test_alternation();
    test_burst();
    test_read();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
